// File: rtl/crop_axis_pkg.sv
// crop_axis_pkg: shared widths, clog2 helper and packed FIFO entry layout
// for the video crop pipeline's AXI-Stream FIFOs.
package crop_axis_pkg;
    localparam int DATA_W_DEF  = 32;
    localparam int COORD_W_DEF = 12;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Entry layout from the LSB up: y, x, user, last, data.
    function automatic int ent_y_lsb(input int cw);
        return 0 * cw;
    endfunction

    function automatic int ent_x_lsb(input int cw);
        return cw;
    endfunction

    function automatic int ent_user_bit(input int cw);
        return 2 * cw;
    endfunction

    function automatic int ent_last_bit(input int cw);
        return 2 * cw + 1;
    endfunction

    function automatic int ent_data_lsb(input int cw);
        return 2 * cw + 2;
    endfunction

    function automatic int ent_w(input int dw, input int cw);
        return dw + 2 * cw + 2;
    endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: generic packed-word first-word-fall-through FIFO with
// full/empty/level; writes at full and reads at empty are ignored.
module sync_fifo_fwft import crop_axis_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   level
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic wr, rd;

    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign level   = count_q;
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr       = wr_en && !full;
        rd       = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr);
        rd_ptr_d = rd_ptr_q + (AW+1)'(rd);
        count_d  = count_q + (AW+1)'(wr) - (AW+1)'(rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/s00_axis_rx.sv
// s00_axis_rx: AXI4-Stream pixel receiver tagging beats with x/y into an FWFT FIFO.
// Define S00_AXIS_LINE_CHECK_EN to build the sticky line-length checker.
module s00_axis_rx import crop_axis_pkg::*; #(
    parameter int C_S_AXIS_TDATA_WIDTH = DATA_W_DEF,
    parameter int C_S_AXIS_FIFO_DEPTH  = 16,
    parameter int C_COORD_WIDTH        = COORD_W_DEF
) (
    input  logic                                 S_AXIS_ACLK,
    input  logic                                 S_AXIS_ARESETN,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic                                 S_AXIS_TVALID,
    output logic                                 S_AXIS_TREADY,
    input  logic                                 S_AXIS_TLAST,
    input  logic                                 S_AXIS_TUSER,
    input  logic                                 rd_en,
    output logic                                 empty,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]      data_out,
    output logic                                 last_out,
    output logic                                 user_out,
    output logic [C_COORD_WIDTH-1:0]             x_out,
    output logic [C_COORD_WIDTH-1:0]             y_out,
    output logic [clog2(C_S_AXIS_FIFO_DEPTH):0]  level,
    output logic                                 line_err,
    input  logic                                 err_clr
);
    localparam int AW = clog2(C_S_AXIS_FIFO_DEPTH);
    localparam int CW = C_COORD_WIDTH;
    localparam int DW = C_S_AXIS_TDATA_WIDTH;
    localparam int EW = ent_w(DW, CW);

    logic tready_q, tready_d, accept, pop, full, unused_ok;
    logic [CW-1:0] x_q, x_d, y_q, y_d, tag_x, tag_y;
    logic [AW+1:0] cnt_nxt;
    logic [EW-1:0] wr_word, rd_word;

    assign S_AXIS_TREADY = tready_q;
    assign data_out = rd_word[ent_data_lsb(CW) +: DW];
    assign last_out = rd_word[ent_last_bit(CW)];
    assign user_out = rd_word[ent_user_bit(CW)];
    assign x_out    = rd_word[ent_x_lsb(CW) +: CW];
    assign y_out    = rd_word[ent_y_lsb(CW) +: CW];

    // TREADY looks one cycle ahead at the occupancy so it never depends on TVALID.
    always_comb begin
        accept   = S_AXIS_TVALID && tready_q;
        pop      = rd_en && !empty;
        cnt_nxt  = {1'b0, level} + (AW+2)'(accept) - (AW+2)'(pop);
        tready_d = cnt_nxt < (AW+2)'(C_S_AXIS_FIFO_DEPTH);
        tag_x    = S_AXIS_TUSER ? '0 : x_q;
        tag_y    = S_AXIS_TUSER ? '0 : y_q;
        x_d      = x_q;
        y_d      = y_q;
        if (accept) begin
            x_d = S_AXIS_TLAST ? '0 : ((&tag_x) ? tag_x : tag_x + CW'(1));
            y_d = !S_AXIS_TLAST ? tag_y : ((&tag_y) ? tag_y : tag_y + CW'(1));
        end
        wr_word = {S_AXIS_TDATA, S_AXIS_TLAST, S_AXIS_TUSER, tag_x, tag_y};
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            tready_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            tready_q <= tready_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (C_S_AXIS_FIFO_DEPTH)
    ) u_fifo (
        .clk     (S_AXIS_ACLK),
        .rst_n   (S_AXIS_ARESETN),
        .wr_en   (accept),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_data (rd_word),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

`ifdef S00_AXIS_LINE_CHECK_EN
    logic [CW:0] ref_len_q, ref_len_d, len;
    logic ref_vld_q, ref_vld_d, err_q, err_d, err_set;

    // The first complete line after a frame start sets the reference length.
    always_comb begin
        len       = {1'b0, tag_x} + (CW+1)'(1);
        ref_len_d = ref_len_q;
        ref_vld_d = ref_vld_q;
        err_set   = 1'b0;
        if (accept && S_AXIS_TUSER) begin
            err_set   = x_q != '0;
            ref_vld_d = 1'b0;
        end
        if (accept && S_AXIS_TLAST) begin
            if (!ref_vld_d) begin
                ref_len_d = len;
                ref_vld_d = 1'b1;
            end else if (len != ref_len_q) begin
                err_set = 1'b1;
            end
        end
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            ref_len_q <= '0;
            ref_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ref_len_q <= ref_len_d;
            ref_vld_q <= ref_vld_d;
            err_q     <= err_d;
        end
    end

    assign line_err  = err_q;
    assign unused_ok = ^{S_AXIS_TSTRB, full};
`else
    assign line_err  = 1'b0;
    assign unused_ok = ^{S_AXIS_TSTRB, full, err_clr};
`endif
endmodule
